// File: rtl/sc_regdeserializer_pkg.sv
// Shared encodings for the serial register path: FSM states and the
// shift-direction selector codes also used by the transmit-side shifter.
package sc_regdeserializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] SEL_MSB_FIRST = 2'b01;
    localparam logic [1:0] SEL_LSB_FIRST = 2'b10;

endpackage

// File: rtl/sc_regdeserializer_bitcounter.sv
// Received-bit counter for the deserializer; saturates at MAX_COUNT and
// flags the count at which the next enabled bit completes a word.
module sc_bitcounter #(
    parameter int MAX_COUNT = 32,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_W'(MAX_COUNT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(MAX_COUNT - 1));

endmodule

// File: rtl/sc_regdeserializer.sv
// Serial-to-parallel register: assembles DATAWIDTH_BUS bits MSB- or LSB-first
// and holds the finished word until it is consumed.
module sc_regdeserializer
    import sc_regdeserializer_pkg::*;
#(
    parameter int DATAWIDTH_BUS                  = 32,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2
) (
    input  logic                                      SC_RegDESERIALIZER_CLOCK_50,
    input  logic                                      SC_RegDESERIALIZER_Reset_InHigh,
    input  logic                                      SC_RegDESERIALIZER_Start_InLow,
    input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_RegDESERIALIZER_ShiftSelection_InLow,
    input  logic                                      SC_RegDESERIALIZER_SerialData_In,
    input  logic                                      SC_RegDESERIALIZER_SerialValid_In,
    input  logic                                      SC_RegDESERIALIZER_Read_InLow,
    output logic [DATAWIDTH_BUS-1:0]                  SC_RegDESERIALIZER_DataBUS_Out,
    output logic                                      SC_RegDESERIALIZER_Ready_Out,
    output logic                                      SC_RegDESERIALIZER_Busy_Out,
    output logic                                      SC_RegDESERIALIZER_Overrun_Out
);

    localparam int W     = DATAWIDTH_BUS;
    localparam int SEL_W = DATAWIDTH_REGSHIFTER_SELECTION;

    logic clk;
    logic rst;
    logic start;
    logic read;
    logic bit_in;
    logic bit_vld;
    logic sel_msb;
    logic sel_lsb;
    logic sel_ok;

    assign clk     = SC_RegDESERIALIZER_CLOCK_50;
    assign rst     = SC_RegDESERIALIZER_Reset_InHigh;
    assign start   = ~SC_RegDESERIALIZER_Start_InLow;
    assign read    = ~SC_RegDESERIALIZER_Read_InLow;
    assign bit_in  = SC_RegDESERIALIZER_SerialData_In;
    assign bit_vld = SC_RegDESERIALIZER_SerialValid_In;
    assign sel_msb = (SC_RegDESERIALIZER_ShiftSelection_InLow == SEL_W'(SEL_MSB_FIRST));
    assign sel_lsb = (SC_RegDESERIALIZER_ShiftSelection_InLow == SEL_W'(SEL_LSB_FIRST));
    assign sel_ok  = sel_msb | sel_lsb;

    state_e         state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [W-1:0]   data_q,  data_d;
    logic           dir_msb_q, dir_msb_d;
    logic           ovr_q,   ovr_d;
    logic           busy_q,  busy_d;
    logic           ready_q, ready_d;
    logic [W-1:0]   shifted;
    logic           cnt_clr;
    logic           cnt_en;
    logic           cnt_tc;

    sc_bitcounter #(
        .MAX_COUNT (W)
    ) u_bitcounter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_comb begin
        shifted = '0;
        if (dir_msb_q) begin
            shifted = {shreg_q[W-2:0], bit_in};
        end else begin
            shifted = {bit_in, shreg_q[W-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        dir_msb_d = dir_msb_q;
        ovr_d     = ovr_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && sel_ok) begin
                    state_d   = SHIFT;
                    dir_msb_d = sel_msb;
                    shreg_d   = '0;
                    cnt_clr   = 1'b1;
                    ovr_d     = 1'b0;
                end
            end

            SHIFT: begin
                // A restart discards any bit arriving on the same edge.
                if (start) begin
                    shreg_d = '0;
                    cnt_clr = 1'b1;
                    if (sel_ok) begin
                        dir_msb_d = sel_msb;
                        ovr_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bit_vld) begin
                    shreg_d = shifted;
                    cnt_en  = 1'b1;
                    if (cnt_tc) begin
                        data_d  = shifted;
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (bit_vld) begin
                    ovr_d = 1'b1;
                end
                if (read) begin
                    state_d = IDLE;
                    if (start && sel_ok) begin
                        state_d   = SHIFT;
                        dir_msb_d = sel_msb;
                        shreg_d   = '0;
                        cnt_clr   = 1'b1;
                        ovr_d     = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_d  = (state_d == SHIFT);
    assign ready_d = (state_d == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            data_q    <= '0;
            dir_msb_q <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            dir_msb_q <= dir_msb_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign SC_RegDESERIALIZER_DataBUS_Out = data_q;
    assign SC_RegDESERIALIZER_Ready_Out   = ready_q;
    assign SC_RegDESERIALIZER_Busy_Out    = busy_q;
    assign SC_RegDESERIALIZER_Overrun_Out = ovr_q;

endmodule

// File: tb/tb_sc_regdeserializer.sv
// Randomized self-checking bench for sc_regdeserializer with an 8-bit bus;
// expected words come from a positional-weight model of the received bits.
`timescale 1ns/1ps
module tb_sc_regdeserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_n;
    logic [1:0]   sel;
    logic         din;
    logic         vld;
    logic         read_n;
    logic [W-1:0] dout;
    logic         ready;
    logic         busy;
    logic         ovr;

    int errors = 0;
    int checks = 0;
    bit tx_q[$];

    always #5 clk = ~clk;

    sc_regdeserializer #(
        .DATAWIDTH_BUS                  (W),
        .DATAWIDTH_REGSHIFTER_SELECTION (2)
    ) dut (
        .SC_RegDESERIALIZER_CLOCK_50             (clk),
        .SC_RegDESERIALIZER_Reset_InHigh         (rst),
        .SC_RegDESERIALIZER_Start_InLow          (start_n),
        .SC_RegDESERIALIZER_ShiftSelection_InLow (sel),
        .SC_RegDESERIALIZER_SerialData_In        (din),
        .SC_RegDESERIALIZER_SerialValid_In       (vld),
        .SC_RegDESERIALIZER_Read_InLow           (read_n),
        .SC_RegDESERIALIZER_DataBUS_Out          (dout),
        .SC_RegDESERIALIZER_Ready_Out            (ready),
        .SC_RegDESERIALIZER_Busy_Out             (busy),
        .SC_RegDESERIALIZER_Overrun_Out          (ovr)
    );

    // First received bit carries weight 2^(W-1) when MSB-first, 2^0 when LSB-first.
    function automatic logic [W-1:0] model_word(input bit msb_first);
        int acc;
        acc = 0;
        for (int i = 0; i < W; i++) begin
            if (tx_q[i]) acc += msb_first ? (1 << (W - 1 - i)) : (1 << i);
        end
        return acc[W-1:0];
    endfunction

    task automatic load_word(input logic [W-1:0] w, input bit msb_first);
        tx_q.delete();
        for (int i = 0; i < W; i++) tx_q.push_back(msb_first ? w[W-1-i] : w[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start_n = 1'b1; read_n = 1'b1; vld = 1'b0; din = 1'b0; sel = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] s);
        start_n = 1'b0; sel = s;
        tick();
        start_n = 1'b1;
    endtask

    task automatic do_read();
        read_n = 1'b0;
        tick();
        read_n = 1'b1;
    endtask

    task automatic send_bits(input int first, input int n, input bit gaps);
        for (int i = first; i < first + n; i++) begin
            if (gaps) begin
                vld = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
            vld = 1'b1; din = tx_q[i];
            tick();
        end
        vld = 1'b0; din = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_n = 1'b1; read_n = 1'b1; vld = 1'b0; din = 1'b0; sel = 2'b00;
        repeat (2) tick();
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", dout); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b exp=0", ovr); end
        rst = 1'b0;
    endtask

    task automatic test_msb_first();
        logic [W-1:0] exp;
        tx_q = '{1, 1, 0, 0, 0, 0, 0, 0};
        exp = model_word(1'b1);
        do_start(2'b01);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL msb_busy_start got=%b exp=1", busy); end
        send_bits(0, W - 1, 1'b0);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL msb_ready_early got=%b exp=0", ready); end
        send_bits(W - 1, 1, 1'b0);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL msb_ready got=%b exp=1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL msb_busy_done got=%b exp=0", busy); end
        checks++; if (dout !== exp) begin errors++; $display("FAIL msb_data got=%h exp=%h", dout, exp); end
        do_read();
        checks++; if (ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL msb_read ready=%b busy=%b exp=0/0", ready, busy); end
        checks++; if (dout !== exp) begin errors++; $display("FAIL msb_hold_after_read got=%h exp=%h", dout, exp); end
    endtask

    task automatic test_lsb_gaps();
        logic [W-1:0] exp;
        tx_q = '{1, 1, 0, 0, 0, 0, 0, 0};
        exp = model_word(1'b0);
        do_start(2'b10);
        send_bits(0, W, 1'b1);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL lsb_ready got=%b exp=1", ready); end
        checks++; if (dout !== exp) begin errors++; $display("FAIL lsb_data got=%h exp=%h", dout, exp); end
        do_read();
    endtask

    task automatic test_random_frames();
        logic [W-1:0] w;
        logic [W-1:0] exp;
        bit msb;
        for (int k = 0; k < 8; k++) begin
            w   = W'($urandom);
            msb = 1'($urandom);
            tx_q.delete();
            for (int i = 0; i < W; i++) tx_q.push_back(1'($urandom));
            exp = model_word(msb);
            do_start(msb ? 2'b01 : 2'b10);
            send_bits(0, W, 1'b1);
            checks++; if (ready !== 1'b1 || dout !== exp) begin errors++; $display("FAIL rand_frame%0d got=%h/%b exp=%h/1", k, dout, ready, exp); end
            do_read();
            load_word(w, msb);
            checks++; if (model_word(msb) !== w) begin errors++; $display("FAIL rand_model%0d got=%h exp=%h", k, model_word(msb), w); end
        end
    endtask

    task automatic test_overrun();
        load_word(8'hA5, 1'b1);
        do_start(2'b01);
        send_bits(0, W, 1'b1);
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_before got=%b exp=0", ovr); end
        tx_q = '{1, 0, 1};
        start_n = 1'b0; sel = 2'b10;
        send_bits(0, 3, 1'b0);
        start_n = 1'b1;
        checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", ovr); end
        checks++; if (dout !== 8'hA5 || ready !== 1'b1) begin errors++; $display("FAIL ovr_hold got=%h/%b exp=a5/1", dout, ready); end
        do_read();
        checks++; if (ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ovr_read ready=%b busy=%b exp=0/0", ready, busy); end
        checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", ovr); end
        do_start(2'b01);
        checks++; if (ovr !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovr_clear ovr=%b busy=%b exp=0/1", ovr, busy); end
        do_reset();
    endtask

    task automatic test_reset_midframe();
        tx_q = '{1, 1, 1, 1};
        do_start(2'b01);
        send_bits(0, 4, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (dout !== 8'h00 || ready !== 1'b0 || busy !== 1'b0 || ovr !== 1'b0) begin
            errors++; $display("FAIL rst_mid got=%h/%b/%b/%b exp=00/0/0/0", dout, ready, busy, ovr);
        end
        load_word(8'h5A, 1'b0);
        do_start(2'b10);
        send_bits(0, W, 1'b1);
        checks++; if (dout !== 8'h5A || ready !== 1'b1) begin errors++; $display("FAIL rst_newframe got=%h/%b exp=5a/1", dout, ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (dout !== 8'h00 || ready !== 1'b0) begin errors++; $display("FAIL rst_in_done got=%h/%b exp=00/0", dout, ready); end
    endtask

    task automatic test_restart();
        tx_q = '{1, 1, 1, 1, 1};
        do_start(2'b10);
        send_bits(0, 5, 1'b0);
        read_n = 1'b0;
        tick();
        read_n = 1'b1;
        checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL read_in_shift busy=%b ready=%b exp=1/0", busy, ready); end
        start_n = 1'b0; sel = 2'b01; vld = 1'b1; din = 1'b1;
        tick();
        start_n = 1'b1; vld = 1'b0; din = 1'b0;
        load_word(8'h3C, 1'b1);
        send_bits(0, W, 1'b1);
        checks++; if (dout !== 8'h3C || ready !== 1'b1) begin errors++; $display("FAIL restart_data got=%h/%b exp=3c/1", dout, ready); end
        do_read();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        load_word(8'h96, 1'b1);
        do_start(2'b01);
        send_bits(0, W, 1'b0);
        start_n = 1'b0; sel = 2'b10;
        tick();
        start_n = 1'b1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL done_start_ignored got=%b exp=1", ready); end
        read_n = 1'b0; start_n = 1'b0; sel = 2'b10;
        tick();
        read_n = 1'b1; start_n = 1'b1;
        checks++; if (ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b ready=%b busy=%b exp=0/1", ready, busy); end
        w = W'($urandom);
        load_word(w, 1'b0);
        send_bits(0, W, 1'b1);
        checks++; if (dout !== w || ready !== 1'b1) begin errors++; $display("FAIL b2b_data got=%h/%b exp=%h/1", dout, ready, w); end
        do_read();
        do_start(2'b00);
        checks++; if (busy !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL sel00 busy=%b ready=%b exp=0/0", busy, ready); end
        do_start(2'b11);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sel11 busy=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_gaps();
        test_random_frames();
        test_overrun();
        test_reset_midframe();
        test_restart();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
